// File: rtl/program_loader.sv
// program_loader: boot-time loader in front of the single-cycle CPU datapath.
// Receives a framed image (A5, N[15:0] LE, 4N data bytes, 8-bit sum checksum)
// from the UART receiver. It packs the data bytes into little-endian 32-bit words
// and writes them to instruction memory starting at word 0. It releases the CPU
// (EN) only after the checksum byte matches.
//
// Ports:
//   CLK        system clock, rising edge
//   RESET      asynchronous active-low reset
//   RxData     received byte, valid while RxValid
//   RxValid    one-cycle strobe per byte
//   IMemWE     one-cycle write pulse per assembled word
//   IMemAddr   word address of the write
//   IMemWData  word being written
//   EN         CPU enable (datapath EN)
//   Done       image loaded and verified
//   Error      sticky frame error (cleared by a new sync byte)
module program_loader #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [7:0]            RxData,
  input  logic                  RxValid,
  output logic                  IMemWE,
  output logic [ADDR_WIDTH-1:0] IMemAddr,
  output logic [31:0]           IMemWData,
  output logic                  EN,
  output logic                  Done,
  output logic                  Error
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0] MaxWords = 17'(1) << ADDR_WIDTH;
  localparam logic [7:0] SyncByte = 8'hA5;

  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StCheck, StRun, StError
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [ADDR_WIDTH:0]   widx_q, widx_d;  // one extra bit so N = 2^ADDR_WIDTH fits
  logic [1:0]            lane_q, lane_d;
  logic [7:0]            cks_q, cks_d;
  logic [23:0]           word_q, word_d;  // first three bytes of the current word
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [15:0]           len_new;
  logic                  in_frame;

  assign len_new  = {RxData, len_q[7:0]};
  assign in_frame = (state_q == StLenLo) || (state_q == StLenHi) ||
                    (state_q == StData)  || (state_q == StCheck);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    widx_d  = widx_q;
    lane_d  = lane_q;
    cks_d   = cks_q;
    word_d  = word_q;
    tmo_d   = '0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    // A byte in the same cycle as the would-be timeout wins: only count idle cycles.
    if (in_frame && !RxValid) begin
      if (tmo_q == TmoLast) begin
        state_d = StError;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (RxValid && RxData == SyncByte) state_d = StLenLo;
      end
      StLenLo: begin
        if (RxValid) begin
          len_d[7:0] = RxData;
          state_d    = StLenHi;
        end
      end
      StLenHi: begin
        if (RxValid) begin
          len_d = len_new;
          if (len_new == 16'd0 || {1'b0, len_new} > MaxWords) begin
            state_d = StError;
          end else begin
            state_d = StData;
            widx_d  = '0;
            lane_d  = 2'd0;
            cks_d   = 8'd0;
          end
        end
      end
      StData: begin
        if (RxValid) begin
          cks_d  = cks_q + RxData;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = widx_q[ADDR_WIDTH-1:0];
            wdata_d = {RxData, word_q};
            widx_d  = widx_q + 1'b1;
            if (17'(widx_q) + 17'd1 == {1'b0, len_q}) state_d = StCheck;
          end else begin
            word_d = {RxData, word_q[23:8]};
          end
        end
      end
      StCheck: begin
        if (RxValid) state_d = (RxData == cks_q) ? StRun : StError;
      end
      StRun: ;  // UART belongs to the running program now
      StError: begin
        if (RxValid && RxData == SyncByte) state_d = StLenLo;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
      len_q   <= '0;
      widx_q  <= '0;
      lane_q  <= '0;
      cks_q   <= '0;
      word_q  <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      lane_q  <= lane_d;
      cks_q   <= cks_d;
      word_q  <= word_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign IMemWE    = we_q;
  assign IMemAddr  = addr_q;
  assign IMemWData = wdata_q;
  assign EN        = (state_q == StRun);
  assign Done      = (state_q == StRun);
  assign Error     = (state_q == StError);

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int AW = 8;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [7:0]    RxData = 8'h00;
  logic          RxValid = 1'b0;
  logic          IMemWE;
  logic [AW-1:0] IMemAddr;
  logic [31:0]   IMemWData;
  logic          EN;
  logic          Done;
  logic          Error;

  program_loader #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .RxData   (RxData),
    .RxValid  (RxValid),
    .IMemWE   (IMemWE),
    .IMemAddr (IMemAddr),
    .IMemWData(IMemWData),
    .EN       (EN),
    .Done     (Done),
    .Error    (Error)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  logic [39:0] exp_q[$];  // {addr, data} of expected writes, in order
  logic [39:0] mon_e;
  logic [7:0]  cks;

  // Write monitor: every IMemWE cycle must match the next expected write.
  always @(negedge CLK) begin
    if (RESET && IMemWE) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL write: unexpected addr=%0h data=%08h", IMemAddr, IMemWData);
      end else begin
        mon_e = exp_q.pop_front();
        if ({IMemAddr, IMemWData} !== mon_e) begin
          bad++;
          $display("FAIL write: got addr=%0h data=%08h want addr=%0h data=%08h",
                   IMemAddr, IMemWData, mon_e[39:32], mon_e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_status(input string name, input logic en, input logic done,
                              input logic err);
    check({name, ".EN"}, 32'(EN), 32'(en));
    check({name, ".Done"}, 32'(Done), 32'(done));
    check({name, ".Error"}, 32'(Error), 32'(err));
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    RxData  = b;
    RxValid = 1'b1;
    @(negedge CLK);
    RxValid = 1'b0;
    RxData  = 8'h00;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic send_word(input logic [7:0] addr, input logic [31:0] w, input int gap);
    exp_q.push_back({addr, w});
    for (int i = 0; i < 4; i++) begin
      cks = cks + w[8*i +: 8];
      send(w[8*i +: 8], gap);
    end
  endtask

  // Two-word frame after the sync byte; B6 is the correct checksum.
  task automatic frame_body(input int gap, input logic [7:0] ck);
    send(8'h02, gap);
    send(8'h00, gap);
    send_word(8'd0, 32'h0000_0013, gap);
    send_word(8'd1, 32'h0010_0093, gap);
    send(ck, gap);
  endtask

  task automatic good_frame(input int gap, input logic [7:0] ck);
    send(8'hA5, gap);
    frame_body(gap, ck);
  endtask

  task automatic do_reset();
    RxValid = 1'b0;
    RESET   = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    // Reset values
    #2 RESET = 1'b0;
    #1;
    check("rst.IMemWE", 32'(IMemWE), 32'd0);
    check("rst.IMemAddr", 32'(IMemAddr), 32'd0);
    check("rst.IMemWData", IMemWData, 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);

    // Noise before sync, good load with spaced bytes, then RUN immunity
    send(8'h00, 1);
    send(8'hFF, 1);
    send(8'h5A, 1);
    good_frame(1, 8'hB6);
    check_status("good", 1'b1, 1'b1, 1'b0);
    check("good.pending", 32'(exp_q.size()), 32'd0);
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'h00, 0);
    for (int i = 0; i < 4; i++) send(8'h13, 0);
    repeat (3) @(negedge CLK);
    check_status("run_immune", 1'b1, 1'b1, 1'b0);

    // Bad checksum, then recovery by a new sync byte
    do_reset();
    good_frame(1, 8'hB7);
    check_status("badck", 1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge CLK);
    check("badck.sticky", 32'(Error), 32'd1);
    send(8'hA5, 0);
    check("badck.clear", 32'(Error), 32'd0);
    frame_body(0, 8'hB6);
    check_status("recover", 1'b1, 1'b1, 1'b0);

    // Length bounds
    do_reset();
    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    check_status("len0", 1'b0, 1'b0, 1'b1);
    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h01, 0);
    check_status("len257", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) send(8'h11, 0);  // must not produce writes
    check("len257.pending", 32'(exp_q.size()), 32'd0);
    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h01, 0);
    cks = 8'h00;
    for (int i = 0; i < 256; i++) begin
      send_word(8'(i), {8'(i), ~8'(i), 8'(i * 3), 8'h5A}, 0);
    end
    send(cks, 0);
    check_status("len256", 1'b1, 1'b1, 1'b0);
    check("len256.pending", 32'(exp_q.size()), 32'd0);

    // Timeout after two data bytes
    do_reset();
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'h00, 0);
    send(8'h13, 0);
    send(8'h00, 0);
    repeat (99) @(negedge CLK);
    check("tmo.idle99", 32'(Error), 32'd0);
    @(negedge CLK);
    check_status("tmo.idle100", 1'b0, 1'b0, 1'b1);

    // Byte arriving on idle cycle 99 or 100 keeps the load alive
    for (int idle = 98; idle <= 99; idle++) begin
      do_reset();
      send(8'hA5, 0);
      send(8'h02, 0);
      send(8'h00, 0);
      exp_q.push_back({8'd0, 32'h0000_0013});
      send(8'h13, 0);
      send(8'h00, 0);
      repeat (idle) @(negedge CLK);
      send(8'h00, 0);
      check("tmo.edge", 32'(Error), 32'd0);
      send(8'h00, 0);
      send_word(8'd1, 32'h0010_0093, 0);
      send(8'hB6, 0);
      check_status("tmo.edge_done", 1'b1, 1'b1, 1'b0);
    end

    // Reset mid-load
    do_reset();
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'h00, 0);
    send_word(8'd0, 32'h0000_0013, 0);
    send(8'h93, 0);
    send(8'h00, 0);
    #2 RESET = 1'b0;
    #1;
    check("midrst.IMemWE", 32'(IMemWE), 32'd0);
    check("midrst.IMemAddr", 32'(IMemAddr), 32'd0);
    check("midrst.IMemWData", IMemWData, 32'd0);
    check_status("midrst", 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    good_frame(0, 8'hB6);
    check_status("after_rst", 1'b1, 1'b1, 1'b0);

    // Back-to-back bytes
    do_reset();
    good_frame(0, 8'hB6);
    check_status("b2b", 1'b1, 1'b1, 1'b0);

    repeat (3) @(negedge CLK);
    check("end.pending", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader sitting directly upstream of the single-cycle CPU datapath. It receives a framed program image as a byte stream from the UART receiver, packs the bytes into 32-bit little-endian words, and writes them through the instruction memory write port starting at word address 0. It verifies a checksum, then releases the CPU by driving the datapath `EN`. The CPU never runs an unverified image.

## Interface

- `ADDR_WIDTH`, default 8: instruction memory word-address width; capacity is 2^ADDR_WIDTH words; legal range 1..16.
- `TIMEOUT_CYCLES`, default 50_000_000: maximum idle cycles between bytes inside a frame before the load aborts.

Ports:

- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `RxData`  in  8  received byte; valid only while `RxValid`=1.
- `RxValid`  in  1  single-cycle strobe, one per received byte.
- `IMemWE`  out  1  instruction memory write enable; one-cycle pulse per word.
- `IMemAddr`  out  ADDR_WIDTH  instruction memory word address.
- `IMemWData`  out  32  word to write.
- `EN`  out  1  CPU enable, wired to the datapath `EN`.
- `Done`  out  1  image loaded and verified; CPU running.
- `Error`  out  1  sticky frame error.

## Operation

- Frame format, in byte order:
  - sync byte 0xA5;
  - word count N, 16-bit little-endian (LEN_LO, then LEN_HI);
  - 4N data bytes, each word little-endian (first byte goes to [7:0]);
  - one checksum byte, equal to the 8-bit modulo-256 sum of the 4N data bytes only.
- FSM states are IDLE, LEN_LO, LEN_HI, DATA, CHECK, RUN, ERROR.
- IDLE:
  - A byte of 0xA5 moves the FSM to LEN_LO.
  - All other bytes are ignored.
- LEN_LO: latch N[7:0], then go to LEN_HI.
- LEN_HI: latch N[15:8].
  - If N==0 or N > 2^ADDR_WIDTH, go to ERROR.
  - Otherwise go to DATA, with word index = 0, byte lane = 0 and checksum = 0.
- DATA:
  - Each byte is shifted into lane 0..3 and added to the checksum.
  - On lane 3, the assembled word is registered to `IMemWData`, the word index to `IMemAddr`, and `IMemWE` is set.
  - The word index then increments and the lane wraps to 0.
  - After word N-1 is written, go to CHECK.
- CHECK:
  - If the received byte equals the checksum, go to RUN.
  - Otherwise go to ERROR.
- RUN:
  - `EN`=1 and `Done`=1, held until reset.
  - All received bytes are ignored, including 0xA5, so the running program may use the UART freely.
- ERROR:
  - `EN`=0 and `Error`=1.
  - A byte of 0xA5 clears `Error` and goes to LEN_LO.
  - All other bytes are ignored.
- Timeout:
  - In LEN_LO, LEN_HI, DATA and CHECK, a counter increments every cycle without `RxValid` and clears on `RxValid`.
  - When it reaches TIMEOUT_CYCLES, go to ERROR.
  - The counter is held at 0 in IDLE, RUN and ERROR.
- Address arithmetic:
  - The word index counter is ADDR_WIDTH+1 bits wide, so N = 2^ADDR_WIDTH is reachable.
  - `IMemAddr` is its low ADDR_WIDTH bits and never wraps within a legal frame.
- The CPU PC stays at its reset value of 0 because `EN` is 0 throughout loading, so execution starts at word 0.

## Timing

- Reset values: FSM in IDLE; `IMemWE`, `IMemAddr`, `IMemWData`, `EN`, `Done` and `Error` all 0; counters 0.
- Asserting reset mid-frame aborts immediately and asynchronously:
  - `IMemWE` drops in the same cycle;
  - no partial word is written.
- `IMemWE` is high for exactly the one cycle after the edge that samples the 4th byte of a word. `IMemAddr` and `IMemWData` are stable and valid during that cycle.
- Back-to-back `RxValid` on consecutive cycles must be accepted with no byte loss. Minimum byte spacing is 1 cycle.
- `EN` and `Done` rise on the edge that samples a correct checksum byte; they are registered, with no combinational path from `RxData`.
- `Error` rises on the edge that detects the fault: bad length, bad checksum, or timeout.
- Simultaneous byte and timeout: if `RxValid`=1 in the cycle the counter would reach TIMEOUT_CYCLES, the byte is accepted and no timeout occurs.
- Load latency: the last data-word write occurs 1 cycle after its 4th byte; `EN` follows the checksum byte by 1 edge.

## Test plan

Bench parameters: ADDR_WIDTH=8, TIMEOUT_CYCLES=100.

- **Good load:** send A5 02 00, 13 00 00 00, 93 00 10 00, then B6.
  - Required: writes addr0=0x00000013 and addr1=0x00100093, one `IMemWE` pulse each.
  - Then `EN`=1, `Done`=1, `Error`=0.
- **Bad checksum:** same frame with B7.
  - Required: `Error`=1 and `EN`=0.
  - A following A5 clears `Error`, and the good frame then loads correctly.
- **Length bounds:**
  - N=0x0000 gives `Error`.
  - N=0x0101 (257) gives `Error` with no writes.
  - N=0x0100 (256) writes addresses 0..255 and ends in RUN.
- **Timeout:** after 2 data bytes, stay idle.
  - 100 idle cycles give `Error`=1.
  - Repeated with a byte arriving on idle cycle 99 or 100 (simultaneous case): no error.
- **Reset mid-load:** pull `RESET` low after 6 data bytes.
  - Required: all outputs 0 at once.
  - The next frame writes starting at addr0.
- **Noise and RUN immunity:**
  - Bytes 00 FF 5A before A5 are ignored and the load succeeds.
  - In RUN, bytes A5 02 00 cause no `IMemWE` and `EN` stays 1.
- **Back-to-back bytes:** a full good frame with `RxValid` held high for consecutive bytes loads identically to the spaced version.
